// File: rtl/motor_pkg.sv
// Shared definitions for the motor command arbiter: FSM state encoding,
// mode constants, owner encoding and speed limits.
// Build option: MOTOR_RAMP_EN selects the slew-limited output path.
package motor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_ESTOP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_AUTO = 2'd2
    } owner_t;

    localparam logic [7:0] MODE_OFF        = 8'd0;
    localparam logic [7:0] MODE_RC         = 8'd1;
    localparam logic [7:0] MODE_ULTRASOUND = 8'd2;

    localparam int SPEED_MAX = 127;

    // Unknown mode values fall back to "no owner" so the motors stay parked.
    function automatic owner_t decode_owner(input logic [7:0] mode);
        owner_t result;
        case (mode)
            MODE_RC:         result = OWN_HOST;
            MODE_ULTRASOUND: result = OWN_AUTO;
            default:         result = OWN_NONE;
        endcase
        return result;
    endfunction

    // Keep commands symmetric: -128 has no positive twin, so clamp it to -127.
    function automatic logic signed [7:0] sat_speed(input logic signed [7:0] v);
        logic signed [7:0] result;
        if (v < -SPEED_MAX) begin
            result = 8'(-SPEED_MAX);
        end else begin
            result = v;
        end
        return result;
    endfunction

endpackage

// File: rtl/motor_cmd_arbiter_if.sv
// Command/status bundle between the mode selector, the two command sources
// and the motor driver. The master side drives commands, the slave side
// (the arbiter) returns the arbitrated speeds and status.
// Build option: MOTOR_RAMP_EN has no effect on this interface.
interface motor_cmd_arbiter_if;
    import motor_pkg::*;

    logic [7:0]        mode;
    logic              host_valid;
    logic signed [7:0] host_speed_a;
    logic signed [7:0] host_speed_b;
    logic              auto_valid;
    logic signed [7:0] auto_speed_a;
    logic signed [7:0] auto_speed_b;
    logic              estop;
    logic signed [7:0] speed_a;
    logic signed [7:0] speed_b;
    logic              alive_strobe;
    owner_t            owner;
    state_t            state;

    modport master (
        output mode, host_valid, host_speed_a, host_speed_b,
        output auto_valid, auto_speed_a, auto_speed_b, estop,
        input  speed_a, speed_b, alive_strobe, owner, state
    );

    modport slave (
        input  mode, host_valid, host_speed_a, host_speed_b,
        input  auto_valid, auto_speed_a, auto_speed_b, estop,
        output speed_a, speed_b, alive_strobe, owner, state
    );

endinterface

// File: rtl/motor_ramp.sv
// Per-channel output stage. With MOTOR_RAMP_EN defined it slews the output
// toward the target by at most RAMP_STEP per tick; otherwise it is a plain
// register that copies the target. clear_i forces the output to zero on the
// next edge regardless of the ramp.
module motor_ramp
    import motor_pkg::*;
`ifdef MOTOR_RAMP_EN
#(
    parameter int RAMP_STEP = 4
)
`endif
(
    input  logic              clk_i,
    input  logic              rst_ni,
`ifdef MOTOR_RAMP_EN
    input  logic              tick_i,
`endif
    input  logic              clear_i,
    input  logic signed [7:0] target_i,
    output logic signed [7:0] speed_o
);

    logic signed [7:0] speed_q;
    logic signed [7:0] speed_d;

`ifdef MOTOR_RAMP_EN
    localparam logic signed [8:0] STEP9 = 9'(RAMP_STEP);
    localparam logic [7:0]        STEP8 = 8'(RAMP_STEP);

    logic signed [8:0] diff;

    // Move one bounded step toward the target per tick, snapping when close enough.
    always_comb begin
        diff    = {target_i[7], target_i} - {speed_q[7], speed_q};
        speed_d = speed_q;
        if (clear_i) begin
            speed_d = '0;
        end else if (tick_i) begin
            if (diff > STEP9) begin
                speed_d = speed_q + STEP8;
            end else if (diff < -STEP9) begin
                speed_d = speed_q - STEP8;
            end else begin
                speed_d = target_i;
            end
        end
    end
`else
    // Without the ramp the output simply follows the target.
    always_comb begin
        speed_d = clear_i ? 8'sd0 : target_i;
    end
`endif

    // Output register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            speed_q <= '0;
        end else begin
            speed_q <= speed_d;
        end
    end

    assign speed_o = speed_q;

endmodule

// File: rtl/motor_cmd_arbiter.sv
// Motor command arbiter: picks the command source from the mode input,
// accepts commands only from that owner, parks the motors on a watchdog
// timeout, mode change or emergency stop, and drives the two motor speeds.
// Build option: MOTOR_RAMP_EN adds the slew limiter, its tick counter and
// the RAMP_DIV/RAMP_STEP parameters; without it outputs follow the targets.
module motor_cmd_arbiter
    import motor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16000000
`ifdef MOTOR_RAMP_EN
   ,parameter int RAMP_DIV       = 16000,
    parameter int RAMP_STEP      = 4
`endif
)
(
    input  logic         clk_16mhz,
    input  logic         rst_n,
    motor_cmd_arbiter_if.slave bus
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]        rstSync_q;
    logic              rstInt_n;

    state_t            state_q, state_d;
    owner_t            curOwner;
    owner_t            prevOwner_q;
    logic signed [7:0] targetA_q, targetA_d;
    logic signed [7:0] targetB_q, targetB_d;
    logic              alive_q, alive_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic              cmdValid;
    logic signed [7:0] cmdA;
    logic signed [7:0] cmdB;
    logic              ownerChanged;

    // Assert internal reset immediately, release it two edges after rst_n rises.
    always_ff @(posedge clk_16mhz or negedge rst_n) begin
        if (!rst_n) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstInt_n = rstSync_q[1];

    assign curOwner     = decode_owner(bus.mode);
    assign ownerChanged = (curOwner != prevOwner_q);

    // Only the current owner's strobe counts; its speeds are saturated on the way in.
    always_comb begin
        cmdValid = 1'b0;
        cmdA     = '0;
        cmdB     = '0;
        case (curOwner)
            OWN_HOST: begin
                cmdValid = bus.host_valid;
                cmdA     = sat_speed(bus.host_speed_a);
                cmdB     = sat_speed(bus.host_speed_b);
            end
            OWN_AUTO: begin
                cmdValid = bus.auto_valid;
                cmdA     = sat_speed(bus.auto_speed_a);
                cmdB     = sat_speed(bus.auto_speed_b);
            end
            default: begin
                cmdValid = 1'b0;
            end
        endcase
    end

    // Next-state logic; priority is estop, then mode change, then command accept.
    always_comb begin
        state_d   = state_q;
        targetA_d = targetA_q;
        targetB_d = targetB_q;
        alive_d   = alive_q;
        wd_d      = wd_q;

        if (bus.estop) begin
            state_d   = ST_ESTOP;
            targetA_d = '0;
            targetB_d = '0;
            wd_d      = '0;
        end else if (state_q == ST_ESTOP || ownerChanged) begin
            state_d   = (curOwner == OWN_NONE) ? ST_IDLE : ST_TIMEOUT;
            targetA_d = '0;
            targetB_d = '0;
            wd_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    targetA_d = '0;
                    targetB_d = '0;
                    wd_d      = '0;
                    if (curOwner != OWN_NONE) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                ST_RUN: begin
                    if (cmdValid) begin
                        targetA_d = cmdA;
                        targetB_d = cmdB;
                        alive_d   = ~alive_q;
                        wd_d      = '0;
                    end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = ST_TIMEOUT;
                        targetA_d = '0;
                        targetB_d = '0;
                        wd_d      = '0;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
                ST_TIMEOUT: begin
                    targetA_d = '0;
                    targetB_d = '0;
                    wd_d      = '0;
                    if (cmdValid) begin
                        state_d   = ST_RUN;
                        targetA_d = cmdA;
                        targetB_d = cmdB;
                        alive_d   = ~alive_q;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    targetA_d = '0;
                    targetB_d = '0;
                    wd_d      = '0;
                end
            endcase
        end
    end

    // FSM, target, watchdog and owner-history registers.
    always_ff @(posedge clk_16mhz or negedge rstInt_n) begin
        if (!rstInt_n) begin
            state_q     <= ST_IDLE;
            prevOwner_q <= OWN_NONE;
            targetA_q   <= '0;
            targetB_q   <= '0;
            alive_q     <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            prevOwner_q <= curOwner;
            targetA_q   <= targetA_d;
            targetB_q   <= targetB_d;
            alive_q     <= alive_d;
            wd_q        <= wd_d;
        end
    end

`ifdef MOTOR_RAMP_EN
    localparam int RC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [RC_W-1:0] rampCnt_q;
    logic            rampTick;

    assign rampTick = (rampCnt_q == RC_W'(RAMP_DIV - 1));

    // Free-running ramp tick divider, independent of the FSM.
    always_ff @(posedge clk_16mhz or negedge rstInt_n) begin
        if (!rstInt_n) begin
            rampCnt_q <= '0;
        end else begin
            rampCnt_q <= rampTick ? '0 : rampCnt_q + 1'b1;
        end
    end

    motor_ramp #(.RAMP_STEP(RAMP_STEP)) u_rampA (
        .clk_i    (clk_16mhz),
        .rst_ni   (rstInt_n),
        .tick_i   (rampTick),
        .clear_i  (bus.estop),
        .target_i (targetA_q),
        .speed_o  (bus.speed_a)
    );

    motor_ramp #(.RAMP_STEP(RAMP_STEP)) u_rampB (
        .clk_i    (clk_16mhz),
        .rst_ni   (rstInt_n),
        .tick_i   (rampTick),
        .clear_i  (bus.estop),
        .target_i (targetB_q),
        .speed_o  (bus.speed_b)
    );
`else
    // Feeding the next-state target makes the output land on the same edge as the target.
    motor_ramp u_rampA (
        .clk_i    (clk_16mhz),
        .rst_ni   (rstInt_n),
        .clear_i  (bus.estop),
        .target_i (targetA_d),
        .speed_o  (bus.speed_a)
    );

    motor_ramp u_rampB (
        .clk_i    (clk_16mhz),
        .rst_ni   (rstInt_n),
        .clear_i  (bus.estop),
        .target_i (targetB_d),
        .speed_o  (bus.speed_b)
    );
`endif

    assign bus.alive_strobe = alive_q;
    assign bus.owner        = curOwner;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_motor_cmd_arbiter.sv
// Directed testbench for motor_cmd_arbiter with a short watchdog and a fast
// ramp tick. Works with or without MOTOR_RAMP_EN.
module tb_motor_cmd_arbiter;
    import motor_pkg::*;

    localparam int TIMEOUT = 100;
`ifdef MOTOR_RAMP_EN
    localparam int DIV  = 2;
    localparam int STEP = 4;
`endif

    logic clk = 1'b0;
    logic rstN;
    int   testsRun = 0;
    int   testsFailed = 0;

    motor_cmd_arbiter_if bus ();

    motor_cmd_arbiter #(
        .TIMEOUT_CYCLES (TIMEOUT)
`ifdef MOTOR_RAMP_EN
       ,.RAMP_DIV       (DIV),
        .RAMP_STEP      (STEP)
`endif
    ) dut (
        .clk_16mhz (clk),
        .rst_n     (rstN),
        .bus       (bus.slave)
    );

    // 16 MHz-style free-running clock (period is arbitrary in simulation).
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] mode, input logic hv,
                                 input logic signed [7:0] ha, input logic signed [7:0] hb,
                                 input logic av,
                                 input logic signed [7:0] aa, input logic signed [7:0] ab,
                                 input logic est);
        bus.mode         = mode;
        bus.host_valid   = hv;
        bus.host_speed_a = ha;
        bus.host_speed_b = hb;
        bus.auto_valid   = av;
        bus.auto_speed_a = aa;
        bus.auto_speed_b = ab;
        bus.estop        = est;
        step(1);
        bus.host_valid   = 1'b0;
        bus.auto_valid   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic signed [15:0] observed,
                               input logic signed [15:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        rstN = 1'b0;
        bus.mode = MODE_OFF;
        bus.host_valid = 1'b0;
        bus.host_speed_a = '0;
        bus.host_speed_b = '0;
        bus.auto_valid = 1'b0;
        bus.auto_speed_a = '0;
        bus.auto_speed_b = '0;
        bus.estop = 1'b0;
        step(3);

        // Reset state
        checkOutput("rst_state", bus.state, ST_IDLE);
        checkOutput("rst_speed_a", bus.speed_a, 0);
        checkOutput("rst_speed_b", bus.speed_b, 0);
        checkOutput("rst_alive", bus.alive_strobe, 0);
        checkOutput("rst_owner_off", bus.owner, OWN_NONE);
        bus.mode = MODE_RC;
        #1;
        checkOutput("rst_owner_rc", bus.owner, OWN_HOST);

        // Release: two synchroniser edges with no transition, then IDLE -> TIMEOUT
        rstN = 1'b1;
        step(2);
        checkOutput("sync_hold_idle", bus.state, ST_IDLE);
        step(1);
        checkOutput("idle_to_timeout", bus.state, ST_TIMEOUT);

        // Host command +100/-50
        applyStimulus(MODE_RC, 1'b1, 8'sd100, -8'sd50, 1'b0, 8'sd0, 8'sd0, 1'b0);
        checkOutput("cmd_state_run", bus.state, ST_RUN);
        checkOutput("cmd_owner", bus.owner, OWN_HOST);
        checkOutput("cmd_alive", bus.alive_strobe, 1);
`ifdef MOTOR_RAMP_EN
        checkOutput("cmd_speed_a_start", bus.speed_a, 0);
        step(25 * DIV + 4);
`endif
        checkOutput("cmd_speed_a", bus.speed_a, 100);
        checkOutput("cmd_speed_b", bus.speed_b, -50);

        // Non-owner strobe ignored
        applyStimulus(MODE_RC, 1'b0, 8'sd0, 8'sd0, 1'b1, 8'sd60, 8'sd60, 1'b0);
        checkOutput("nonowner_speed_a", bus.speed_a, 100);
        checkOutput("nonowner_alive", bus.alive_strobe, 1);
        checkOutput("nonowner_state", bus.state, ST_RUN);

        // Watchdog: TIMEOUT exactly TIMEOUT edges after accept
        applyStimulus(MODE_RC, 1'b1, 8'sd20, 8'sd20, 1'b0, 8'sd0, 8'sd0, 1'b0);
        checkOutput("wd_alive", bus.alive_strobe, 0);
        step(TIMEOUT - 1);
        checkOutput("wd_before", bus.state, ST_RUN);
        step(1);
        checkOutput("wd_timeout", bus.state, ST_TIMEOUT);
        step(12);
        checkOutput("wd_speed_zero", bus.speed_a, 0);

        // Estop during RUN at +80
        applyStimulus(MODE_RC, 1'b1, 8'sd80, 8'sd80, 1'b0, 8'sd0, 8'sd0, 1'b0);
`ifdef MOTOR_RAMP_EN
        step(20 * DIV + 4);
`endif
        checkOutput("es_speed_before", bus.speed_a, 80);
        applyStimulus(MODE_RC, 1'b0, 8'sd0, 8'sd0, 1'b0, 8'sd0, 8'sd0, 1'b1);
        checkOutput("es_state", bus.state, ST_ESTOP);
        checkOutput("es_speed_a", bus.speed_a, 0);
        checkOutput("es_speed_b", bus.speed_b, 0);
        applyStimulus(MODE_RC, 1'b0, 8'sd0, 8'sd0, 1'b0, 8'sd0, 8'sd0, 1'b0);
        checkOutput("es_release_state", bus.state, ST_TIMEOUT);
        step(10);
        checkOutput("es_release_speed", bus.speed_a, 0);

        // Mode change drops a same-cycle command
        applyStimulus(MODE_ULTRASOUND, 1'b1, 8'sd50, 8'sd50, 1'b0, 8'sd0, 8'sd0, 1'b0);
        checkOutput("mc_state", bus.state, ST_TIMEOUT);
        checkOutput("mc_owner", bus.owner, OWN_AUTO);
        checkOutput("mc_alive", bus.alive_strobe, 1);
        checkOutput("mc_speed_a", bus.speed_a, 0);

        // Auto command with -128 saturates to -127
        applyStimulus(MODE_ULTRASOUND, 1'b0, 8'sd0, 8'sd0, 1'b1, -8'sd128, 8'sd30, 1'b0);
        checkOutput("sat_state", bus.state, ST_RUN);
        checkOutput("sat_alive", bus.alive_strobe, 0);
`ifdef MOTOR_RAMP_EN
        step(32 * DIV + 4);
`endif
        checkOutput("sat_speed_a", bus.speed_a, -127);
        checkOutput("sat_speed_b", bus.speed_b, 30);

        // Unknown mode behaves as OFF
        applyStimulus(8'd7, 1'b0, 8'sd0, 8'sd0, 1'b0, 8'sd0, 8'sd0, 1'b0);
        checkOutput("badmode_state", bus.state, ST_IDLE);
        checkOutput("badmode_owner", bus.owner, OWN_NONE);

        // Reset mid-ramp clears outputs asynchronously
        applyStimulus(MODE_RC, 1'b0, 8'sd0, 8'sd0, 1'b0, 8'sd0, 8'sd0, 1'b0);
        applyStimulus(MODE_RC, 1'b1, 8'sd100, 8'sd100, 1'b0, 8'sd0, 8'sd0, 1'b0);
`ifndef MOTOR_RAMP_EN
        checkOutput("pre_reset_speed", bus.speed_a, 100);
`endif
        step(6);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_rst_speed_a", bus.speed_a, 0);
        checkOutput("async_rst_speed_b", bus.speed_b, 0);
        checkOutput("async_rst_state", bus.state, ST_IDLE);
        checkOutput("async_rst_alive", bus.alive_strobe, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
